// File: rtl/sfp_ctrl_pkg.sv
// Shared definitions for the sfp lane sequencer: state encoding and stall counter width.
// The top level and the testbench both import this package so they decode states the same way.
package sfp_ctrl_pkg;

  localparam int STATE_BW = 3;
  localparam int STALL_BW = 16;

  typedef enum logic [STATE_BW-1:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_ACC  = 3'd2,
    S_RELU = 3'd3,
    S_OUT  = 3'd4
  } state_e;

endpackage

// File: rtl/sfp_beat_cnt.sv
// Beat counter for one accumulate command: cleared while the lane is cleared, stepped per accepted beat.
// 'last' flags that the next accept completes the command (count == num_acc - 1).
module sfp_beat_cnt #(
  parameter int cnt_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  input  logic [cnt_bw-1:0] num_acc,
  output logic              last
);

  localparam logic [cnt_bw-1:0] ONE = {{(cnt_bw-1){1'b0}}, 1'b1};

  logic [cnt_bw-1:0] cnt_q;
  logic [cnt_bw-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Only meaningful while accumulating; num_acc == 0 never reaches the ACC state.
  assign last = (cnt_q == (num_acc - ONE));

endmodule

// File: rtl/sfp_ctrl.sv
// Sequencer for one sfp accumulate/threshold lane: clear, gate num_acc beats, one relu step, hold result.
// Optional feature macro SFP_CTRL_STALL_CNT_EN adds a saturating count of starved ACC cycles (stall_cnt).
module sfp_ctrl
  import sfp_ctrl_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int cnt_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [cnt_bw-1:0]  num_acc,
  input  logic [psum_bw-1:0] thres_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               sfp_clr,
  output logic               sfp_acc,
  output logic               sfp_relu,
  output logic [psum_bw-1:0] sfp_thres,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
`ifdef SFP_CTRL_STALL_CNT_EN
  , output logic [STALL_BW-1:0] stall_cnt
`endif
);

  // A beat wider than the accumulator would be truncated inside the lane.
  if (bw > psum_bw) begin : g_bw_check
    $error("sfp_ctrl: beat width bw must not exceed psum_bw");
  end

  state_e             state_q;
  state_e             state_d;
  logic [cnt_bw-1:0]  num_q;
  logic [psum_bw-1:0] thres_q;
  logic               cmdLoad;
  logic               accept;
  logic               lastBeat;

  assign cmdLoad = (state_q == S_IDLE) && start;
  assign accept  = (state_q == S_ACC) && in_valid;

  sfp_beat_cnt #(
    .cnt_bw (cnt_bw)
  ) u_beat_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_q == S_CLR),
    .inc     (accept),
    .num_acc (num_q),
    .last    (lastBeat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      thres_q <= '0;
    end else begin
      state_q <= state_d;
      if (cmdLoad) begin
        num_q   <= num_acc;
        thres_q <= thres_in;
      end
    end
  end

  // Every control output comes from the registered state; only sfp_acc and done also qualify on the handshake input.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    sfp_clr   = 1'b0;
    sfp_acc   = 1'b0;
    sfp_relu  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        sfp_clr = 1'b1;
        state_d = (num_q == '0) ? S_RELU : S_ACC;
      end
      S_ACC: begin
        in_ready = 1'b1;
        sfp_acc  = in_valid;
        if (in_valid && lastBeat) begin
          state_d = S_RELU;
        end
      end
      S_RELU: begin
        sfp_relu = 1'b1;
        state_d  = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign sfp_thres = thres_q;

`ifdef SFP_CTRL_STALL_CNT_EN
  logic [STALL_BW-1:0] stall_q;
  logic [STALL_BW-1:0] stall_d;

  // Restarts with each command and is left untouched after the last beat so the parent can read it later.
  always_comb begin
    stall_d = stall_q;
    if (state_q == S_CLR) begin
      stall_d = '0;
    end else if ((state_q == S_ACC) && !in_valid && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_sfp_ctrl.sv
// Self-checking bench for sfp_ctrl: vector table, hand-written corner sequences and random commands.
// A behavioural sfp lane and a transaction-level timing model supply every expected value.
module tb_sfp_ctrl;
  import sfp_ctrl_pkg::*;

  localparam int BW      = 4;
  localparam int PSUM_BW = 16;
  localparam int CNT_BW  = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [CNT_BW-1:0]  num_acc = '0;
  logic [PSUM_BW-1:0] thres_in = '0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic               in_ready;
  logic               sfp_clr;
  logic               sfp_acc;
  logic               sfp_relu;
  logic [PSUM_BW-1:0] sfp_thres;
  logic               out_valid;
  logic               busy;
  logic               done;
`ifdef SFP_CTRL_STALL_CNT_EN
  logic [STALL_BW-1:0] stall_cnt;
`endif

  logic [BW-1:0] beat = '0;
  logic [BW-1:0] beatQ[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  sfp_ctrl #(
    .bw      (BW),
    .psum_bw (PSUM_BW),
    .cnt_bw  (CNT_BW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_acc   (num_acc),
    .thres_in  (thres_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sfp_clr   (sfp_clr),
    .sfp_acc   (sfp_acc),
    .sfp_relu  (sfp_relu),
    .sfp_thres (sfp_thres),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
`ifdef SFP_CTRL_STALL_CNT_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the sfp lane; deliberately not reset so a stale psum would show up.
  logic [PSUM_BW-1:0] laneAcc = '0;
  logic               laneOut = 1'b0;
  always @(posedge clk) begin
    if (sfp_clr) laneAcc <= '0;
    else if (sfp_acc) laneAcc <= laneAcc + {{(PSUM_BW-BW){beat[BW-1]}}, beat};
    if (sfp_relu) laneOut <= ($signed(laneAcc) >= $signed(sfp_thres));
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int readStall();
`ifdef SFP_CTRL_STALL_CNT_EN
    return int'(stall_cnt);
`else
    return 0;
`endif
  endfunction

  // One full command; gap<0 means random in_valid, otherwise 'gap' idle cycles after each non-final beat.
  task automatic applyStimulus(input int num, input int thres, input int gap, input int outDelay,
                               input bit poke, input string tag,
                               output int res, output int stall, output int mSum,
                               output int mStall, output int ovLat);
    int startCyc, mAcc, mRelu, mDone, idleLeft, firstOv;
    int accErr, clrErr, reluErr, ovErr, doneErr, busyErr, overlap, thrErr;
    bit inWin, expAcc, finished;
    mAcc = 0; mSum = 0; mStall = 0; idleLeft = 0; firstOv = -1;
    accErr = 0; clrErr = 0; reluErr = 0; ovErr = 0; doneErr = 0; busyErr = 0; overlap = 0; thrErr = 0;
    @(negedge clk);
    start = 1'b1;
    num_acc = num[CNT_BW-1:0];
    thres_in = thres[PSUM_BW-1:0];
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    startCyc = cyc;
    checkOutput({tag, " idle_before_start"}, int'(busy), 0);
    mRelu = (num == 0) ? startCyc + 2 : -1;
    mDone = (mRelu >= 0) ? mRelu + 1 + outDelay : -1;
    forever begin
      @(negedge clk);
      finished = (mRelu >= 0) && (cyc > mDone);
      inWin = (cyc >= startCyc + 2) && (mAcc < num);
      if (poke && !finished) begin
        start = 1'b1;
        num_acc = CNT_BW'($urandom);
        thres_in = PSUM_BW'($urandom);
      end else begin
        start = 1'b0;
      end
      if (inWin) begin
        if (gap < 0) in_valid = ($urandom_range(0, 2) != 0);
        else if (idleLeft > 0) begin
          in_valid = 1'b0;
          idleLeft--;
        end else in_valid = 1'b1;
      end else begin
        in_valid = 1'($urandom_range(0, 1));
      end
      beat = (mAcc < beatQ.size()) ? beatQ[mAcc] : '0;
      out_ready = (mRelu >= 0) && (cyc >= mDone);
      #1;
      expAcc = inWin && in_valid;
      if (sfp_acc !== expAcc || in_ready !== inWin) accErr++;
      if (sfp_clr !== (cyc == startCyc + 1)) clrErr++;
      if (sfp_relu !== ((mRelu >= 0) && (cyc == mRelu))) reluErr++;
      if (out_valid !== ((mRelu >= 0) && (cyc > mRelu) && (cyc <= mDone))) ovErr++;
      if (done !== ((mRelu >= 0) && (cyc == mDone))) doneErr++;
      if (busy !== !finished) busyErr++;
      if (sfp_acc && sfp_relu) overlap++;
      if (sfp_thres !== thres[PSUM_BW-1:0]) thrErr++;
      if (out_valid && firstOv < 0) firstOv = cyc;
      if (inWin && !in_valid) mStall++;
      if (finished) break;
      if (expAcc) begin
        mSum = mSum + $signed(beat);
        mAcc++;
        if (mAcc == num) begin
          mRelu = cyc + 1;
          mDone = mRelu + 1 + outDelay;
        end else begin
          idleLeft = (gap > 0) ? gap : 0;
        end
      end
      if (cyc - startCyc > 2000) begin
        checkOutput({tag, " timeout"}, 1, 0);
        break;
      end
    end
    res = int'(laneOut);
    stall = readStall();
    ovLat = firstOv - startCyc;
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput({tag, " acc_gating"}, accErr, 0);
    checkOutput({tag, " clr_pulse"}, clrErr, 0);
    checkOutput({tag, " relu_pulse"}, reluErr, 0);
    checkOutput({tag, " out_valid"}, ovErr, 0);
    checkOutput({tag, " done_pulse"}, doneErr, 0);
    checkOutput({tag, " busy"}, busyErr, 0);
    checkOutput({tag, " acc_relu_overlap"}, overlap, 0);
    checkOutput({tag, " thres_latch"}, thrErr, 0);
  endtask

  typedef struct {
    int             num;
    int             thres;
    int             gap;
    int             outDelay;
    bit             poke;
    logic [3:0][3:0] beats;
    int             expRes;
    int             expStall;
    int             expLat;
  } vec_t;

  vec_t vecs[6];
  int res, stall, mSum, mStall, ovLat;

  initial begin
    vecs[0] = '{4, 5, 0, 0, 1'b0, 16'h4321, 1, 0, 7};
    vecs[1] = '{3, 0, 2, 0, 1'b0, 16'h01EE, 0, 4, 10};
    vecs[2] = '{0, 0, 0, 0, 1'b0, 16'h0000, 1, 0, 3};
    vecs[3] = '{2, 3, 0, 5, 1'b1, 16'h0011, 0, 0, 5};
    vecs[4] = '{1, -1, 0, 1, 1'b0, 16'h0008, 0, 0, 4};
    vecs[5] = '{4, 10, 1, 2, 1'b0, 16'h0F77, 1, 3, 10};

    // Reset state, with handshake inputs active to show they cannot leak through.
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset ctrl_outs", int'({in_ready, sfp_clr, sfp_acc, sfp_relu, out_valid, done}), 0);
    checkOutput("reset sfp_thres", int'(sfp_thres), 0);
    checkOutput("reset stall_cnt", readStall(), 0);
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      beatQ.delete();
      for (int i = 0; i < 4; i++) beatQ.push_back(vecs[k].beats[i]);
      applyStimulus(vecs[k].num, vecs[k].thres, vecs[k].gap, vecs[k].outDelay, vecs[k].poke,
                    $sformatf("vec%0d", k), res, stall, mSum, mStall, ovLat);
      checkOutput($sformatf("vec%0d result", k), res, vecs[k].expRes);
      checkOutput($sformatf("vec%0d out_latency", k), ovLat, vecs[k].expLat);
`ifdef SFP_CTRL_STALL_CNT_EN
      checkOutput($sformatf("vec%0d stall_cnt", k), stall, vecs[k].expStall);
`endif
    end

    // Abort mid-ACC after two of six beats, then a fresh command must not see the stale psum.
    @(negedge clk);
    start = 1'b1;
    num_acc = 8'd6;
    thres_in = 16'd7;
    beat = 4'd4;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    checkOutput("abort in_ready_before", int'(in_ready), 1);
    reset = 1'b1;
    #1;
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort ctrl_outs", int'({in_ready, sfp_clr, sfp_acc, sfp_relu, out_valid, done}), 0);
    checkOutput("abort sfp_thres", int'(sfp_thres), 0);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    beatQ.delete();
    beatQ.push_back(4'd3);
    beatQ.push_back(4'd3);
    applyStimulus(2, 7, 0, 0, 1'b0, "after_abort", res, stall, mSum, mStall, ovLat);
    checkOutput("after_abort result", res, 0);

    // Full-scale count: 255 continuous beats, no wrap, out_valid 258 cycles after start.
    beatQ.delete();
    for (int i = 0; i < 255; i++) beatQ.push_back(BW'($urandom_range(0, 15)));
    applyStimulus(255, $urandom_range(0, 200) - 100, 0, 0, 1'b0, "full", res, stall, mSum, mStall, ovLat);
    checkOutput("full result", res, (mSum >= int'(sfp_thres) - ((sfp_thres[PSUM_BW-1]) ? 65536 : 0)) ? 1 : 0);
    checkOutput("full out_latency", ovLat, 258);

    // Random commands against the model.
    for (int r = 0; r < 10; r++) begin
      int num, thres, gap, od;
      num = $urandom_range(0, 12);
      thres = $urandom_range(0, 50) - 20;
      gap = $urandom_range(0, 3) - 1;
      od = $urandom_range(0, 3);
      beatQ.delete();
      for (int i = 0; i < num; i++) beatQ.push_back(BW'($urandom_range(0, 15)));
      applyStimulus(num, thres, gap, od, 1'($urandom_range(0, 1)), $sformatf("rand%0d", r),
                    res, stall, mSum, mStall, ovLat);
      checkOutput($sformatf("rand%0d result", r), res, (mSum >= thres) ? 1 : 0);
`ifdef SFP_CTRL_STALL_CNT_EN
      checkOutput($sformatf("rand%0d stall_cnt", r), stall, mStall);
`endif
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
